// File: rtl/cosim_chg_packer.sv
// cosim_chg_packer: ping-pong packer of retired instructions, accesses and traps into step records.
// Ports: clk/rst_n (async active-low); in_rdy plus insn_*/op_*/trap_*/step_end form the event input side;
// rec_vld/rec_ack plus rec_* form the held-record handshake; rd_insn_*/rd_op_* read held slots combinationally.
module cosim_chg_packer #(
    parameter int MAX_INSN = 4,
    parameter int MAX_OP   = 16,
    parameter int XLEN     = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            in_rdy,
    input  logic            insn_vld,
    input  logic [1:0]      insn_prv,
    input  logic [XLEN-1:0] insn_pc,
    input  logic [63:0]     insn_ir,
    input  logic            op_vld,
    input  logic [7:0]      op_access,
    input  logic [XLEN-1:0] op_addr,
    input  logic [XLEN-1:0] op_data,
    input  logic            trap_vld,
    input  logic            trap_dbg,
    input  logic [1:0]      trap_prv,
    input  logic [7:0]      trap_cause,
    input  logic [7:0]      trap_dcause,
    input  logic [XLEN-1:0] trap_badaddr,
    input  logic            step_end,
    output logic            rec_vld,
    input  logic            rec_ack,
    output logic [2:0]      rec_ins_num,
    output logic [4:0]      rec_op_num,
    output logic            rec_trp,
    output logic            rec_dbg,
    output logic            rec_ovf,
    output logic            rec_err,
    output logic [1:0]      rec_trap_prv,
    output logic [7:0]      rec_trap_cause,
    output logic [7:0]      rec_trap_dcause,
    output logic [XLEN-1:0] rec_trap_badaddr,
    input  logic [1:0]      rd_insn_idx,
    output logic [1:0]      rd_insn_prv,
    output logic [XLEN-1:0] rd_insn_pc,
    output logic [63:0]     rd_insn_ir,
    input  logic [3:0]      rd_op_idx,
    output logic [7:0]      rd_op_access,
    output logic [XLEN-1:0] rd_op_addr,
    output logic [XLEN-1:0] rd_op_data,
    output logic [1:0]      rd_op_inum
);
    localparam int IW = $clog2(MAX_INSN);
    localparam int OW = $clog2(MAX_OP);
    logic            fsel, held, closed;
    logic [2:0]      icnt [2];
    logic [4:0]      ocnt [2];
    logic            trp [2], dbg [2], ovf [2], err [2];
    logic [1:0]      tprv [2];
    logic [7:0]      tcause [2], tdcause [2];
    logic [XLEN-1:0] tbad [2];
    logic [1:0]      iprv [2][MAX_INSN];
    logic [XLEN-1:0] ipc [2][MAX_INSN];
    logic [63:0]     iir [2][MAX_INSN];
    logic [7:0]      oacc [2][MAX_OP];
    logic [XLEN-1:0] oaddr [2][MAX_OP], odata [2][MAX_OP];
    logic [1:0]      oinum [2][MAX_OP];
    logic [2:0]      ic, ic_n;
    logic [4:0]      oc;
    logic            ins_hit, ins_take, op_hit, op_bad, op_take, tr_hit, tr_first;
    logic            close, free, swap, new_ovf;
    logic [1:0]      op_inum;
    assign held     = ~fsel;
    assign in_rdy   = ~closed;
    assign ic       = icnt[fsel];
    assign oc       = ocnt[fsel];
    assign ins_hit  = in_rdy & insn_vld;
    assign ins_take = ins_hit & (ic < 3'(MAX_INSN));
    assign ic_n     = ic + {2'b0, ins_take};
    assign op_hit   = in_rdy & op_vld;
    assign op_bad   = op_access > 8'd17;
    assign op_take  = op_hit & ~op_bad & (oc < 5'(MAX_OP));
    // ops bind to the newest instruction, including one retired in the same cycle
    assign op_inum  = (ic_n == 3'd0) ? 2'd0 : 2'(ic_n - 3'd1);
    assign tr_hit   = in_rdy & trap_vld;
    assign tr_first = ~(trp[fsel] | dbg[fsel]);
    assign new_ovf  = (ins_hit & ~ins_take) | (op_hit & ~op_bad & ~op_take) | (tr_hit & ~tr_first);
    // a closed fill buffer waits (in_rdy=0) until the held side is released
    assign close    = in_rdy & step_end;
    assign free     = ~rec_vld | rec_ack;
    assign swap     = (close | closed) & free;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsel    <= 1'b0;
            closed  <= 1'b0;
            rec_vld <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                icnt[b]    <= '0;
                ocnt[b]    <= '0;
                trp[b]     <= 1'b0;
                dbg[b]     <= 1'b0;
                ovf[b]     <= 1'b0;
                err[b]     <= 1'b0;
                tprv[b]    <= '0;
                tcause[b]  <= '0;
                tdcause[b] <= '0;
                tbad[b]    <= '0;
            end
        end else begin
            fsel       <= swap ? ~fsel : fsel;
            closed     <= (close | closed) & ~free;
            rec_vld    <= swap | (rec_vld & ~rec_ack);
            icnt[fsel] <= ic_n;
            ocnt[fsel] <= op_take ? oc + 5'd1 : oc;
            ovf[fsel]  <= ovf[fsel] | new_ovf;
            err[fsel]  <= err[fsel] | (op_hit & op_bad);
            if (tr_hit && tr_first) begin
                trp[fsel]     <= ~trap_dbg;
                dbg[fsel]     <= trap_dbg;
                tprv[fsel]    <= trap_prv;
                tcause[fsel]  <= trap_cause;
                tdcause[fsel] <= trap_dcause;
                tbad[fsel]    <= trap_badaddr;
            end
            // the buffer released by the consumer becomes the next fill buffer
            if (swap) begin
                icnt[held]    <= '0;
                ocnt[held]    <= '0;
                trp[held]     <= 1'b0;
                dbg[held]     <= 1'b0;
                ovf[held]     <= 1'b0;
                err[held]     <= 1'b0;
                tprv[held]    <= '0;
                tcause[held]  <= '0;
                tdcause[held] <= '0;
                tbad[held]    <= '0;
            end
        end
    end
    // slot payloads need no reset: reads beyond the counts are masked to zero
    always_ff @(posedge clk) begin
        if (ins_take) begin
            iprv[fsel][ic[IW-1:0]] <= insn_prv;
            ipc[fsel][ic[IW-1:0]]  <= insn_pc;
            iir[fsel][ic[IW-1:0]]  <= insn_ir;
        end
        if (op_take) begin
            oacc[fsel][oc[OW-1:0]]  <= op_access;
            oaddr[fsel][oc[OW-1:0]] <= op_addr;
            odata[fsel][oc[OW-1:0]] <= op_data;
            oinum[fsel][oc[OW-1:0]] <= op_inum;
        end
    end
    assign rec_ins_num      = rec_vld ? icnt[held] : '0;
    assign rec_op_num       = rec_vld ? ocnt[held] : '0;
    assign rec_trp          = rec_vld & trp[held];
    assign rec_dbg          = rec_vld & dbg[held];
    assign rec_ovf          = rec_vld & ovf[held];
    assign rec_err          = rec_vld & err[held];
    assign rec_trap_prv     = rec_vld ? tprv[held] : '0;
    assign rec_trap_cause   = rec_vld ? tcause[held] : '0;
    assign rec_trap_dcause  = rec_vld ? tdcause[held] : '0;
    assign rec_trap_badaddr = rec_vld ? tbad[held] : '0;
    assign rd_insn_prv      = ({1'b0, rd_insn_idx} < rec_ins_num) ? iprv[held][rd_insn_idx] : '0;
    assign rd_insn_pc       = ({1'b0, rd_insn_idx} < rec_ins_num) ? ipc[held][rd_insn_idx] : '0;
    assign rd_insn_ir       = ({1'b0, rd_insn_idx} < rec_ins_num) ? iir[held][rd_insn_idx] : '0;
    assign rd_op_access     = ({1'b0, rd_op_idx} < rec_op_num) ? oacc[held][rd_op_idx] : '0;
    assign rd_op_addr       = ({1'b0, rd_op_idx} < rec_op_num) ? oaddr[held][rd_op_idx] : '0;
    assign rd_op_data       = ({1'b0, rd_op_idx} < rec_op_num) ? odata[held][rd_op_idx] : '0;
    assign rd_op_inum       = ({1'b0, rd_op_idx} < rec_op_num) ? oinum[held][rd_op_idx] : '0;
endmodule

// File: tb/tb_cosim_chg_packer.sv
// tb_cosim_chg_packer: directed stimulus checked every cycle against a record-queue model, plus literal spot checks.
module tb_cosim_chg_packer;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_rdy, insn_vld, op_vld, trap_vld, trap_dbg, step_end, rec_vld, rec_ack;
    logic [1:0]  insn_prv, trap_prv, rd_insn_idx, rd_insn_prv, rd_op_inum, rec_trap_prv;
    logic [63:0] insn_pc, insn_ir, op_addr, op_data, trap_badaddr, rec_trap_badaddr;
    logic [63:0] rd_insn_pc, rd_insn_ir, rd_op_addr, rd_op_data;
    logic [7:0]  op_access, trap_cause, trap_dcause, rec_trap_cause, rec_trap_dcause, rd_op_access;
    logic [2:0]  rec_ins_num;
    logic [4:0]  rec_op_num;
    logic        rec_trp, rec_dbg, rec_ovf, rec_err;
    logic [3:0]  rd_op_idx;
    always #5 clk = ~clk;
    cosim_chg_packer dut (
        .clk(clk), .rst_n(rst_n), .in_rdy(in_rdy),
        .insn_vld(insn_vld), .insn_prv(insn_prv), .insn_pc(insn_pc), .insn_ir(insn_ir),
        .op_vld(op_vld), .op_access(op_access), .op_addr(op_addr), .op_data(op_data),
        .trap_vld(trap_vld), .trap_dbg(trap_dbg), .trap_prv(trap_prv), .trap_cause(trap_cause),
        .trap_dcause(trap_dcause), .trap_badaddr(trap_badaddr), .step_end(step_end),
        .rec_vld(rec_vld), .rec_ack(rec_ack), .rec_ins_num(rec_ins_num), .rec_op_num(rec_op_num),
        .rec_trp(rec_trp), .rec_dbg(rec_dbg), .rec_ovf(rec_ovf), .rec_err(rec_err),
        .rec_trap_prv(rec_trap_prv), .rec_trap_cause(rec_trap_cause), .rec_trap_dcause(rec_trap_dcause),
        .rec_trap_badaddr(rec_trap_badaddr), .rd_insn_idx(rd_insn_idx), .rd_insn_prv(rd_insn_prv),
        .rd_insn_pc(rd_insn_pc), .rd_insn_ir(rd_insn_ir), .rd_op_idx(rd_op_idx),
        .rd_op_access(rd_op_access), .rd_op_addr(rd_op_addr), .rd_op_data(rd_op_data), .rd_op_inum(rd_op_inum)
    );
    typedef struct packed {
        logic [2:0]        ni;
        logic [4:0]        no;
        logic              trp, dbg, ovf, err;
        logic [1:0]        tprv;
        logic [7:0]        tc, tdc;
        logic [63:0]       tba;
        logic [3:0][1:0]   iprv;
        logic [3:0][63:0]  ipc, iir;
        logic [15:0][7:0]  oacc;
        logic [15:0][63:0] oaddr, odata;
        logic [15:0][1:0]  oinum;
    } rec_t;
    rec_t q[$];
    rec_t cur;
    int n_chk = 0, n_fail = 0;
    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    // model: completed records queue up; the front is the held record, at most one waits behind it
    always @(posedge clk or negedge rst_n) begin : model
        rec_t n;
        bit rdy;
        if (!rst_n) begin
            q.delete();
            cur = '0;
        end else begin
            n = cur;
            rdy = q.size() < 2;
            if (rdy && insn_vld) begin
                if (n.ni < 4) begin
                    n.iprv[n.ni] = insn_prv;
                    n.ipc[n.ni] = insn_pc;
                    n.iir[n.ni] = insn_ir;
                    n.ni = n.ni + 3'd1;
                end else n.ovf = 1'b1;
            end
            if (rdy && op_vld) begin
                if (op_access > 17) n.err = 1'b1;
                else if (n.no < 16) begin
                    n.oacc[n.no] = op_access;
                    n.oaddr[n.no] = op_addr;
                    n.odata[n.no] = op_data;
                    n.oinum[n.no] = (n.ni == 0) ? 2'd0 : 2'(n.ni - 3'd1);
                    n.no = n.no + 5'd1;
                end else n.ovf = 1'b1;
            end
            if (rdy && trap_vld) begin
                if (n.trp || n.dbg) n.ovf = 1'b1;
                else begin
                    n.trp = ~trap_dbg;
                    n.dbg = trap_dbg;
                    n.tprv = trap_prv;
                    n.tc = trap_cause;
                    n.tdc = trap_dcause;
                    n.tba = trap_badaddr;
                end
            end
            if (rec_ack && q.size() > 0) void'(q.pop_front());
            if (rdy && step_end) begin
                q.push_back(n);
                cur = '0;
            end else cur = n;
        end
    end
    always @(negedge clk) begin : check
        rec_t e;
        e = '0;
        if (q.size() > 0) e = q[0];
        chk("in_rdy", in_rdy, q.size() < 2);
        chk("rec_vld", rec_vld, q.size() > 0);
        chk("ins_num", rec_ins_num, e.ni);
        chk("op_num", rec_op_num, e.no);
        chk("flags", {rec_trp, rec_dbg, rec_ovf, rec_err}, {e.trp, e.dbg, e.ovf, e.err});
        chk("trap_prv", rec_trap_prv, e.tprv);
        chk("trap_cause", rec_trap_cause, e.tc);
        chk("trap_dcause", rec_trap_dcause, e.tdc);
        chk("trap_badaddr", rec_trap_badaddr, e.tba);
        chk("rd_insn_prv", rd_insn_prv, {1'b0, rd_insn_idx} < e.ni ? e.iprv[rd_insn_idx] : 2'd0);
        chk("rd_insn_pc", rd_insn_pc, {1'b0, rd_insn_idx} < e.ni ? e.ipc[rd_insn_idx] : 64'd0);
        chk("rd_insn_ir", rd_insn_ir, {1'b0, rd_insn_idx} < e.ni ? e.iir[rd_insn_idx] : 64'd0);
        chk("rd_op_access", rd_op_access, {1'b0, rd_op_idx} < e.no ? e.oacc[rd_op_idx] : 8'd0);
        chk("rd_op_addr", rd_op_addr, {1'b0, rd_op_idx} < e.no ? e.oaddr[rd_op_idx] : 64'd0);
        chk("rd_op_data", rd_op_data, {1'b0, rd_op_idx} < e.no ? e.odata[rd_op_idx] : 64'd0);
        chk("rd_op_inum", rd_op_inum, {1'b0, rd_op_idx} < e.no ? e.oinum[rd_op_idx] : 2'd0);
    end
    task automatic tick();
        @(posedge clk);
        #1;
        {insn_vld, op_vld, trap_vld, step_end, rec_ack} = '0;
    endtask
    task automatic insn(input logic [63:0] pc);
        insn_vld = 1'b1;
        insn_pc = pc;
        insn_ir = pc ^ 64'hA5A5_0013;
        insn_prv = pc[3:2];
    endtask
    task automatic op(input logic [7:0] a, input logic [63:0] ad, input logic [63:0] d);
        op_vld = 1'b1;
        op_access = a;
        op_addr = ad;
        op_data = d;
    endtask
    task automatic trap(input logic dbg, input logic [7:0] c, input logic [63:0] bad);
        trap_vld = 1'b1;
        trap_dbg = dbg;
        trap_prv = 2'd1;
        trap_cause = c;
        trap_dcause = c + 8'd1;
        trap_badaddr = bad;
    endtask
    task automatic ack();
        rec_ack = 1'b1;
        tick();
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            rd_insn_idx = 2'(i);
            rd_op_idx = 4'(i * 5);
            tick();
        end
    endtask
    initial begin
        {insn_vld, op_vld, trap_vld, trap_dbg, step_end, rec_ack} = '0;
        insn_prv = '0; insn_pc = '0; insn_ir = '0; op_access = '0; op_addr = '0; op_data = '0;
        trap_prv = '0; trap_cause = '0; trap_dcause = '0; trap_badaddr = '0;
        rd_insn_idx = '0; rd_op_idx = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_rdy", in_rdy, 1);
        chk("rst_rec_vld", rec_vld, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        insn(64'h8000_0000);
        op(8'd1, 64'd5, 64'h1234);
        step_end = 1'b1;
        tick();
        @(negedge clk);
        chk("s1_vld", rec_vld, 1);
        chk("s1_ins", rec_ins_num, 1);
        chk("s1_op", rec_op_num, 1);
        chk("s1_inum", rd_op_inum, 0);
        chk("s1_pc", rd_insn_pc, 64'h8000_0000);
        chk("s1_data", rd_op_data, 64'h1234);
        ack();
        for (int i = 0; i < 5; i++) begin
            insn(64'h1000 + 64'(i * 4));
            tick();
        end
        step_end = 1'b1;
        tick();
        rd_insn_idx = 2'd3;
        @(negedge clk);
        chk("s2_ins", rec_ins_num, 4);
        chk("s2_ovf", rec_ovf, 1);
        chk("s2_pc3", rd_insn_pc, 64'h100C);
        ack();
        op(8'd1, 64'h10, 64'h11);
        tick();
        insn(64'h2000);
        tick();
        insn(64'h2004);
        op(8'd2, 64'h20, 64'h22);
        tick();
        op(8'd18, 64'h30, 64'h33);
        tick();
        op(8'd17, 64'h40, 64'h44);
        step_end = 1'b1;
        tick();
        rd_op_idx = 4'd1;
        @(negedge clk);
        chk("s3_op", rec_op_num, 3);
        chk("s3_err", rec_err, 1);
        chk("s3_inum", rd_op_inum, 1);
        chk("s3_acc", rd_op_access, 2);
        ack();
        for (int i = 0; i < 17; i++) begin
            op(8'(i), 64'(i), 64'(i * 3));
            tick();
        end
        step_end = 1'b1;
        tick();
        rd_op_idx = 4'd15;
        @(negedge clk);
        chk("ops_num", rec_op_num, 16);
        chk("ops_ovf", rec_ovf, 1);
        chk("ops_addr15", rd_op_addr, 15);
        ack();
        step_end = 1'b1;
        tick();
        @(negedge clk);
        chk("empty_vld", rec_vld, 1);
        chk("empty_num", {rec_ins_num, rec_op_num}, 0);
        ack();
        ack();
        insn(64'hA0);
        step_end = 1'b1;
        tick();
        insn(64'hB0);
        step_end = 1'b1;
        tick();
        rd_insn_idx = 2'd0;
        @(negedge clk);
        chk("s4_rdy0", in_rdy, 0);
        chk("s4_pcA", rd_insn_pc, 64'hA0);
        insn(64'hC0);
        step_end = 1'b1;
        tick();
        ack();
        @(negedge clk);
        chk("s4_rdy1", in_rdy, 1);
        chk("s4_vld", rec_vld, 1);
        chk("s4_pcB", rd_insn_pc, 64'hB0);
        chk("s4_ins", rec_ins_num, 1);
        ack();
        trap(1'b0, 8'd2, 64'h40);
        tick();
        trap(1'b0, 8'd5, 64'h50);
        step_end = 1'b1;
        tick();
        @(negedge clk);
        chk("s5_trp", rec_trp, 1);
        chk("s5_cause", rec_trap_cause, 2);
        chk("s5_ovf", rec_ovf, 1);
        chk("s5_bad", rec_trap_badaddr, 64'h40);
        ack();
        trap(1'b1, 8'd7, 64'h60);
        step_end = 1'b1;
        tick();
        @(negedge clk);
        chk("dbg_flags", {rec_trp, rec_dbg, rec_ovf}, 3'b010);
        chk("dbg_dcause", rec_trap_dcause, 8);
        rec_ack = 1'b1;
        insn(64'hD0);
        step_end = 1'b1;
        tick();
        idle(4);
        insn(64'hE0);
        op(8'd3, 64'h1, 64'h2);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("s6_vld", rec_vld, 0);
        chk("s6_rdy", in_rdy, 1);
        chk("s6_num", {rec_ins_num, rec_op_num}, 0);
        chk("s6_pc", rd_insn_pc, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        insn(64'h77);
        step_end = 1'b1;
        tick();
        rd_insn_idx = 2'd0;
        @(negedge clk);
        chk("s6_slot0", rd_insn_pc, 64'h77);
        chk("s6_ins", rec_ins_num, 1);
        ack();
        idle(6);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cosim_chg_packer.md
COSIM_CHG_PACKER -- requirements
Module: cosim_chg_packer

Interface
REQ-001 SHALL have parameters: MAX_INSN, default 4, instructions per record; MAX_OP, default 16, operations per record; XLEN, default 64, address/data/pc width.
REQ-002 SHALL have ports, in order:
- clk  in  1  sole clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_rdy  out  1  fill buffer accepts events.
- insn_vld  in  1  retired instruction this cycle.
- insn_prv  in  2  privilege: U=0, S=1, H=2, M=3.
- insn_pc  in  XLEN  retired pc.
- insn_ir  in  64  instruction bits.
- op_vld  in  1  architectural access this cycle.
- op_access  in  8  access code: RdXPR=0 .. STuint64=17, in enum order.
- op_addr, op_data  in  XLEN each  access address and data.
- trap_vld  in  1  trap/debug entry this cycle.
- trap_dbg  in  1  debug entry, not trap.
- trap_prv  in  2  target privilege.
- trap_cause, trap_dcause  in  8 each  trap cause, debug cause codes.
- trap_badaddr  in  XLEN  faulting address.
- step_end  in  1  closes current record.
- rec_vld  out  1  held record available.
- rec_ack  in  1  consumer releases held record.
- rec_ins_num  out  3  instructions in record, 0..MAX_INSN.
- rec_op_num  out  5  ops in record, 0..MAX_OP.
- rec_trp, rec_dbg, rec_ovf, rec_err  out  1 each  record flags.
- rec_trap_prv, rec_trap_cause, rec_trap_dcause, rec_trap_badaddr  out  2/8/8/XLEN  held trap info.
- rd_insn_idx  in  2  instruction read index.
- rd_insn_prv, rd_insn_pc, rd_insn_ir  out  2/XLEN/64  combinational read of held instruction slot.
- rd_op_idx  in  4  op read index.
- rd_op_access, rd_op_addr, rd_op_data, rd_op_inum  out  8/XLEN/XLEN/2  combinational read of held op slot.

Function
REQ-003 SHALL hold two record buffers (ping-pong): one filling, one held for the consumer.
REQ-004 SHALL capture events only when in_rdy=1; events with in_rdy=0 SHALL be ignored; producer is responsible for holding them.
REQ-005 insn_vld SHALL write slot ins_cnt and increment ins_cnt; when ins_cnt=MAX_INSN the instruction SHALL be dropped and ovf set.
REQ-006 op_vld SHALL write slot op_cnt and increment op_cnt; when op_cnt=MAX_OP the op SHALL be dropped and ovf set.
REQ-007 Op inum SHALL be (ins_cnt after this cycle's insn capture) minus 1, saturating at 0; same-cycle insn and op SHALL bind the op to that instruction.
REQ-008 op_access >17 SHALL drop the op and set err; op_cnt SHALL be unchanged.
REQ-009 First trap_vld in a record SHALL latch trap fields and set trp (trap_dbg=0) or dbg (trap_dbg=1); later trap_vld in the same record SHALL be ignored and set ovf.
REQ-010 step_end SHALL close the fill buffer after that cycle's events are captured; an empty record (counts 0, no flags) SHALL still be emitted.
REQ-011 On close with held side free (rec_vld=0 or rec_ack same cycle): buffers swap, rec_vld=1 next cycle, new fill buffer cleared (counts, flags zero), in_rdy stays 1.
REQ-012 On close with held side occupied and no rec_ack: in_rdy SHALL drop next cycle; buffer stays closed; swap occurs the cycle after rec_ack; in_rdy returns 1 after the swap.
REQ-013 rec_ack with rec_vld=1 and no pending closed buffer SHALL clear rec_vld next cycle; rec_ack with rec_vld=0 SHALL be ignored.
REQ-014 Held record outputs SHALL be stable while rec_vld=1 and no swap occurs.
REQ-015 Read ports SHALL return zero for indices at or beyond rec_ins_num/rec_op_num.

Reset
REQ-016 rst_n=0 SHALL asynchronously clear both buffers, all counters and flags; rec_vld=0, in_rdy=1, all rec_*/rd_* outputs 0.
REQ-017 Reset mid-record SHALL discard all captured events; first event after rst_n release SHALL land in slot 0.

Verification
REQ-018 Bench SHALL cover:
- insn pc=0x80000000 + op WrXPR addr=5 data=0x1234 same cycle, step_end -> next cycle rec_vld=1, ins_num=1, op_num=1, op inum=0.
- 5 insns + step_end -> ins_num=4, ovf=1, slot 3 holds 4th pc.
- op_access=18 -> op_num unchanged, err=1.
- Two step_ends without rec_ack -> in_rdy=0 after second; rec_ack -> swap, second record shown, in_rdy=1.
- trap_vld cause=2 then trap_vld cause=5 same record -> trp=1, cause=2, ovf=1.
- rst_n low during fill with rec_vld=1 -> rec_vld=0, in_rdy=1, counts 0.
